// File: rtl/mips_irq_controller_if.sv
// rtl/mips_irq_controller_if.sv - request, register and core-handshake bundle for mips_irq_controller
// master = core/config side, slave = interrupt controller.

interface mips_irq_controller_if #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3,
  parameter int DATA_W  = 16
);

  logic [NUM_SRC-1:0] irq_src;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [DATA_W-1:0]  cfg_wdata;
  logic [DATA_W-1:0]  cfg_rdata;
  logic               interrupt;
  logic [ID_W-1:0]    int_id;
  logic               int_ack;
  logic               int_eoi;

  modport master (
    output irq_src,
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    output int_ack,
    output int_eoi,
    input  cfg_rdata,
    input  interrupt,
    input  int_id
  );

  modport slave (
    input  irq_src,
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    input  int_ack,
    input  int_eoi,
    output cfg_rdata,
    output interrupt,
    output int_id
  );

endinterface

// File: rtl/mips_irq_controller.sv
// rtl/mips_irq_controller.sv - 8-source prioritised interrupt controller feeding the MIPS core
// Sync + rising-edge capture into PENDING, mask, lowest-index-wins, ack/eoi handshake.

module mips_irq_controller #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3,
  parameter int DATA_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_irq_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_INSV = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] insv_q, insv_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               int_q, int_d;

  logic [NUM_SRC-1:0] rise_w;
  logic [NUM_SRC-1:0] cand_w;
  logic [NUM_SRC-1:0] w1c_w;
  logic [NUM_SRC-1:0] ack_clr_w;
  logic [NUM_SRC-1:0] id_onehot_w;
  logic [ID_W-1:0]    win_id_w;
  logic               ack_take_w;
  logic               eoi_take_w;
  logic               unused_wdata_w;

  assign rise_w      = sync2_q & ~prev_q;
  assign cand_w      = pend_q & mask_q;
  assign id_onehot_w = {{(NUM_SRC-1){1'b0}}, 1'b1} << id_q;
  assign ack_take_w  = (state_q == S_ASSERT) && bus.int_ack;
  assign eoi_take_w  = (state_q == S_SERVICE) && bus.int_eoi;
  assign w1c_w       = (bus.cfg_we && bus.cfg_addr == A_PEND) ? bus.cfg_wdata[NUM_SRC-1:0] : '0;
  assign ack_clr_w   = ack_take_w ? id_onehot_w : '0;

  assign unused_wdata_w = ^bus.cfg_wdata[DATA_W-1:NUM_SRC];

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    win_id_w = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand_w[i]) win_id_w = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      insv_q  <= '0;
      id_q    <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= bus.irq_src;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      insv_q  <= insv_d;
      id_q    <= id_d;
      int_q   <= int_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (|cand_w)     state_d = S_ASSERT;
      S_ASSERT:  if (bus.int_ack) state_d = S_SERVICE;
      S_SERVICE: if (bus.int_eoi) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // A new edge on the same cycle as a clear keeps the bit set.
  always_comb begin
    mask_d = mask_q;
    if (bus.cfg_we && bus.cfg_addr == A_MASK) mask_d = bus.cfg_wdata[NUM_SRC-1:0];

    pend_d = (pend_q & ~(w1c_w | ack_clr_w)) | rise_w;

    insv_d = insv_q;
    if (ack_take_w) insv_d = insv_q | id_onehot_w;
    if (eoi_take_w) insv_d = insv_q & ~id_onehot_w;

    id_d = id_q;
    if (state_q == S_IDLE && |cand_w) id_d = win_id_w;
    if (eoi_take_w)                   id_d = '0;

    int_d = (state_d == S_ASSERT);
  end

  always_comb begin
    bus.cfg_rdata = '0;
    unique case (bus.cfg_addr)
      A_MASK: bus.cfg_rdata[NUM_SRC-1:0] = mask_q;
      A_PEND: bus.cfg_rdata[NUM_SRC-1:0] = pend_q;
      A_INSV: bus.cfg_rdata[NUM_SRC-1:0] = insv_q;
      A_STAT: begin
        bus.cfg_rdata[1:0]      = state_q;
        bus.cfg_rdata[4 +: ID_W] = id_q;
      end
      default: bus.cfg_rdata = '0;
    endcase
  end

  assign bus.interrupt = int_q;
  assign bus.int_id    = id_q;

endmodule
